// File: rtl/rc_vc_unit_if.sv
// rc_vc_unit_if: route request/response bundle between input buffer and RC stage
interface rc_vc_unit_if #(
  parameter int VC_NUM           = 2,
  parameter int DEST_ADDR_SIZE_X = 4,
  parameter int DEST_ADDR_SIZE_Y = 4
);
  localparam int VCW = VC_NUM > 1 ? $clog2(VC_NUM) : 1;
  logic                        req_valid_i;
  logic [VCW-1:0]              req_vc_i;
  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i;
  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i;
  logic                        req_ready_o;
  logic [VC_NUM-1:0]           release_i;
  logic [VC_NUM-1:0]           route_valid_o;
  logic [VC_NUM-1:0][2:0]      route_port_o;
  logic                        err_o;
  modport master (
    output req_valid_i, req_vc_i, x_dest_i, y_dest_i, release_i,
    input  req_ready_o, route_valid_o, route_port_o, err_o
  );
  modport slave (
    input  req_valid_i, req_vc_i, x_dest_i, y_dest_i, release_i,
    output req_ready_o, route_valid_o, route_port_o, err_o
  );
endinterface

// File: rtl/rc_vc_unit.sv
// rc_vc_unit: per-VC registered DOR route computation for a 2D-mesh input port
// Port encoding: LOCAL=0 NORTH=1 SOUTH=2 WEST=3 EAST=4 (Y grows downward, so -dy is NORTH)
module rc_vc_unit #(
  parameter int X_CURRENT        = 0,
  parameter int Y_CURRENT        = 0,
  parameter int DEST_ADDR_SIZE_X = 4,
  parameter int DEST_ADDR_SIZE_Y = 4,
  parameter int MESH_SIZE_X      = 4,
  parameter int MESH_SIZE_Y      = 4,
  parameter int VC_NUM           = 2,
  parameter int YX_ORDER         = 0
) (
  input logic         clk,
  input logic         rst,
  rc_vc_unit_if.slave bus
);
  localparam int VCW = VC_NUM > 1 ? $clog2(VC_NUM) : 1;
  localparam logic [2:0] LOCAL = 3'd0;
  localparam logic [2:0] NORTH = 3'd1;
  localparam logic [2:0] SOUTH = 3'd2;
  localparam logic [2:0] WEST  = 3'd3;
  localparam logic [2:0] EAST  = 3'd4;
  localparam logic signed [DEST_ADDR_SIZE_X:0] XC = (DEST_ADDR_SIZE_X+1)'(X_CURRENT);
  localparam logic signed [DEST_ADDR_SIZE_Y:0] YC = (DEST_ADDR_SIZE_Y+1)'(Y_CURRENT);
  logic signed [DEST_ADDR_SIZE_X:0] w_dx;
  logic signed [DEST_ADDR_SIZE_Y:0] w_dy;
  logic                   w_xn, w_xz, w_yn, w_yz, w_bad, w_vc_ok, w_xfer;
  logic [2:0]             w_port;
  logic [VC_NUM-1:0]      r_valid;
  logic [VC_NUM-1:0][2:0] r_port;
  logic                   r_err;
  assign w_dx = $signed({1'b0, bus.x_dest_i}) - XC;
  assign w_dy = $signed({1'b0, bus.y_dest_i}) - YC;
  assign w_xn = w_dx[DEST_ADDR_SIZE_X];
  assign w_yn = w_dy[DEST_ADDR_SIZE_Y];
  assign w_xz = w_dx == '0;
  assign w_yz = w_dy == '0;
  assign w_port = YX_ORDER != 0
    ? (w_yn ? NORTH : !w_yz ? SOUTH : w_xn ? WEST : !w_xz ? EAST : LOCAL)
    : (w_xn ? WEST : !w_xz ? EAST : w_yn ? NORTH : !w_yz ? SOUTH : LOCAL);
  assign w_bad = 32'(bus.x_dest_i) >= 32'(MESH_SIZE_X) || 32'(bus.y_dest_i) >= 32'(MESH_SIZE_Y);
  assign w_vc_ok = 32'(bus.req_vc_i) < 32'(VC_NUM);
  assign bus.req_ready_o = w_vc_ok && (!r_valid[bus.req_vc_i] || bus.release_i[bus.req_vc_i]);
  assign w_xfer = bus.req_valid_i && bus.req_ready_o;
  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    logic w_hit;
    assign w_hit = w_xfer && bus.req_vc_i == VCW'(v);
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid[v] <= 1'b0;
        r_port[v]  <= LOCAL;
      end else if (w_hit) begin
        r_valid[v] <= !w_bad;
        if (!w_bad) r_port[v] <= w_port;
      end else if (bus.release_i[v]) begin
        r_valid[v] <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) r_err <= !rst && w_xfer && w_bad;
  assign bus.route_valid_o = r_valid;
  assign bus.route_port_o  = r_port;
  assign bus.err_o         = r_err;
endmodule

// File: tb/tb_rc_vc_unit.sv
// tb_rc_vc_unit: directed checks of XY/YX routing, hold, release, errors and reset
module tb_rc_vc_unit;
  localparam logic [2:0] LOCAL = 3'd0;
  localparam logic [2:0] NORTH = 3'd1;
  localparam logic [2:0] SOUTH = 3'd2;
  localparam logic [2:0] WEST  = 3'd3;
  localparam logic [2:0] EAST  = 3'd4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  rc_vc_unit_if #(.VC_NUM(2), .DEST_ADDR_SIZE_X(4), .DEST_ADDR_SIZE_Y(4)) bxy ();
  rc_vc_unit_if #(.VC_NUM(2), .DEST_ADDR_SIZE_X(4), .DEST_ADDR_SIZE_Y(4)) byx ();
  rc_vc_unit #(.X_CURRENT(1), .Y_CURRENT(1), .DEST_ADDR_SIZE_X(4), .DEST_ADDR_SIZE_Y(4),
    .MESH_SIZE_X(4), .MESH_SIZE_Y(4), .VC_NUM(2), .YX_ORDER(0)) dut_xy (.clk(clk), .rst(rst), .bus(bxy));
  rc_vc_unit #(.X_CURRENT(1), .Y_CURRENT(1), .DEST_ADDR_SIZE_X(4), .DEST_ADDR_SIZE_Y(4),
    .MESH_SIZE_X(4), .MESH_SIZE_Y(4), .VC_NUM(2), .YX_ORDER(1)) dut_yx (.clk(clk), .rst(rst), .bus(byx));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_xy(input logic v, input logic vc, input logic [3:0] x, input logic [3:0] y, input logic [1:0] rel);
    bxy.req_valid_i = v;
    bxy.req_vc_i    = vc;
    bxy.x_dest_i    = x;
    bxy.y_dest_i    = y;
    bxy.release_i   = rel;
    #1;
  endtask
  task automatic set_yx(input logic v, input logic vc, input logic [3:0] x, input logic [3:0] y, input logic [1:0] rel);
    byx.req_valid_i = v;
    byx.req_vc_i    = vc;
    byx.x_dest_i    = x;
    byx.y_dest_i    = y;
    byx.release_i   = rel;
    #1;
  endtask
  initial begin
    set_xy(0, 0, 0, 0, 2'b00);
    set_yx(0, 0, 0, 0, 2'b00);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", bxy.route_valid_o, 2'b00);
    chk("rst_port0", bxy.route_port_o[0], LOCAL);
    chk("rst_port1", bxy.route_port_o[1], LOCAL);
    chk("rst_err", bxy.err_o, 0);
    chk("rst_ready", bxy.req_ready_o, 1);
    set_xy(1, 0, 3, 1, 2'b00);
    chk("xy_east_ready", bxy.req_ready_o, 1);
    tick();
    chk("xy_east_valid", bxy.route_valid_o, 2'b01);
    chk("xy_east_port", bxy.route_port_o[0], EAST);
    set_xy(1, 1, 1, 0, 2'b00);
    tick();
    chk("xy_north_valid", bxy.route_valid_o, 2'b11);
    chk("xy_north_port", bxy.route_port_o[1], NORTH);
    set_xy(0, 0, 0, 0, 2'b11);
    tick();
    chk("rel_both_valid", bxy.route_valid_o, 2'b00);
    chk("rel_keeps_port", bxy.route_port_o[0], EAST);
    set_xy(1, 0, 1, 1, 2'b00);
    tick();
    chk("xy_local_port", bxy.route_port_o[0], LOCAL);
    set_xy(1, 1, 0, 3, 2'b00);
    tick();
    chk("xy_west_port", bxy.route_port_o[1], WEST);
    chk("xy_west_valid", bxy.route_valid_o, 2'b11);
    set_xy(0, 0, 0, 0, 2'b11);
    tick();
    set_xy(1, 0, 3, 1, 2'b00);
    tick();
    chk("hold_setup", bxy.route_port_o[0], EAST);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) set_xy(1, 1, 1, 2, 2'b00);
      else set_xy(1, 0, 0, 0, 2'b00);
      chk($sformatf("hold_ready_%0d", i), bxy.req_ready_o, i == 2);
      tick();
      chk($sformatf("hold_port_%0d", i), bxy.route_port_o[0], EAST);
      chk($sformatf("hold_valid_%0d", i), bxy.route_valid_o[0], 1);
    end
    chk("hold_vc1_valid", bxy.route_valid_o, 2'b11);
    chk("hold_vc1_port", bxy.route_port_o[1], SOUTH);
    set_xy(1, 0, 1, 3, 2'b01);
    chk("relreq_ready", bxy.req_ready_o, 1);
    tick();
    chk("relreq_valid", bxy.route_valid_o, 2'b11);
    chk("relreq_port", bxy.route_port_o[0], SOUTH);
    set_xy(0, 0, 0, 0, 2'b11);
    tick();
    set_xy(1, 0, 3, 1, 2'b00);
    tick();
    set_xy(0, 0, 0, 0, 2'b01);
    tick();
    chk("relonly_valid", bxy.route_valid_o, 2'b00);
    set_xy(0, 0, 0, 0, 2'b10);
    tick();
    chk("relidle_valid", bxy.route_valid_o, 2'b00);
    chk("relidle_port0", bxy.route_port_o[0], EAST);
    chk("relidle_port1", bxy.route_port_o[1], SOUTH);
    set_xy(1, 1, 5, 1, 2'b00);
    chk("oom_x_ready", bxy.req_ready_o, 1);
    tick();
    chk("oom_x_err", bxy.err_o, 1);
    chk("oom_x_valid", bxy.route_valid_o, 2'b00);
    set_xy(0, 0, 0, 0, 2'b00);
    tick();
    chk("oom_x_err_pulse", bxy.err_o, 0);
    chk("oom_x_port", bxy.route_port_o[1], SOUTH);
    set_xy(1, 1, 3, 4, 2'b00);
    tick();
    chk("oom_y_err", bxy.err_o, 1);
    chk("oom_y_valid", bxy.route_valid_o, 2'b00);
    set_xy(1, 0, 3, 1, 2'b00);
    tick();
    chk("oom_y_err_pulse", bxy.err_o, 0);
    chk("oom_rel_setup", bxy.route_valid_o, 2'b01);
    set_xy(1, 0, 3, 4, 2'b01);
    chk("oom_rel_ready", bxy.req_ready_o, 1);
    tick();
    chk("oom_rel_err", bxy.err_o, 1);
    chk("oom_rel_valid", bxy.route_valid_o, 2'b00);
    set_xy(0, 0, 0, 0, 2'b00);
    set_yx(1, 0, 0, 3, 2'b00);
    tick();
    chk("yx_south_port", byx.route_port_o[0], SOUTH);
    chk("yx_south_valid", byx.route_valid_o, 2'b01);
    set_yx(1, 0, 0, 1, 2'b01);
    tick();
    chk("yx_west_port", byx.route_port_o[0], WEST);
    set_yx(1, 0, 1, 0, 2'b01);
    tick();
    chk("yx_north_port", byx.route_port_o[0], NORTH);
    set_yx(0, 0, 0, 0, 2'b00);
    set_xy(1, 0, 3, 1, 2'b00);
    tick();
    set_xy(1, 1, 1, 0, 2'b00);
    tick();
    chk("midrst_setup", bxy.route_valid_o, 2'b11);
    rst = 1'b1;
    set_xy(1, 0, 3, 3, 2'b00);
    tick();
    rst = 1'b0;
    set_xy(0, 0, 0, 0, 2'b00);
    chk("midrst_valid", bxy.route_valid_o, 2'b00);
    chk("midrst_err", bxy.err_o, 0);
    chk("midrst_port0", bxy.route_port_o[0], LOCAL);
    chk("midrst_port1", bxy.route_port_o[1], LOCAL);
    chk("midrst_yx_valid", byx.route_valid_o, 2'b00);
    tick();
    chk("midrst_after", bxy.route_valid_o, 2'b00);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rc_vc_unit.md
Name: rc_vc_unit

Overview:
Registered, per-virtual-channel route computation stage for a 2D-mesh router input port. It accepts head-flit destination coordinates on a valid/ready request interface and computes the output port with DOR in either XY or YX order. It holds one route per VC until the tail flit releases it. It sits between the input buffer and the VC/switch allocators and flags destinations outside the mesh.

Parameters:
X_CURRENT, 0, X coordinate of this router
Y_CURRENT, 0, Y coordinate of this router
DEST_ADDR_SIZE_X, 4, width of X destination field
DEST_ADDR_SIZE_Y, 4, width of Y destination field
MESH_SIZE_X, 4, number of columns; legal X is 0..MESH_SIZE_X-1
MESH_SIZE_Y, 4, number of rows; legal Y is 0..MESH_SIZE_Y-1
VC_NUM, 2, virtual channels per input port
YX_ORDER, 0, 0 = XY order (X resolved first); 1 = YX order (Y resolved first)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  1  head flit presents a route request
req_vc_i  in  $clog2(VC_NUM)  VC of the request
x_dest_i  in  DEST_ADDR_SIZE_X  destination X
y_dest_i  in  DEST_ADDR_SIZE_Y  destination Y
req_ready_o  out  1  request accepted this cycle
release_i  in  VC_NUM  one-hot-per-bit; tail flit of that VC has left, free its route
route_valid_o  out  VC_NUM  route held for VC
route_port_o  out  VC_NUM x port_t  held output port per VC (port_t: LOCAL, NORTH, SOUTH, WEST, EAST)
err_o  out  1  one-cycle pulse: accepted request had out-of-mesh destination

Behaviour:
- Reset: all route_valid_o=0, all route_port_o=LOCAL, err_o=0. Reset in the middle of an operation discards all held routes; release_i and requests in the reset cycle are ignored.
- Offsets:
  - Offsets are computed as signed values one bit wider than the destination field: dx = x_dest_i - X_CURRENT, dy = y_dest_i - Y_CURRENT.
  - There is no wrap-around. Destinations are unsigned, so x_dest=0 at X_CURRENT=3 gives dx=-3 (WEST).
- XY order: dx<0 -> WEST; dx>0 -> EAST; dx==0 and dy<0 -> NORTH; dx==0 and dy>0 -> SOUTH; both zero -> LOCAL.
- YX order: dy<0 -> NORTH; dy>0 -> SOUTH; dy==0 and dx<0 -> WEST; dy==0 and dx>0 -> EAST; both zero -> LOCAL.
- Coordinate scheme: X grows left to right; Y grows top to bottom.
- Handshake:
  - req_ready_o is combinational: req_ready_o = !route_valid_o[req_vc_i] | release_i[req_vc_i].
  - A transfer occurs when req_valid_i && req_ready_o && !rst.
- Latency: on a legal transfer in cycle N, route_valid_o[vc]=1 and route_port_o[vc] are valid from cycle N+1. They stay stable until release.
- Release:
  - release_i[v]=1 clears route_valid_o[v] at the next edge. route_port_o[v] keeps its last value.
  - Release of a VC that holds no route is a no-op.
- Simultaneous release and request on the same VC: the request is accepted and the new route overwrites, so route_valid_o stays 1 with the new port at N+1.
- Releases on other VCs in the same cycle are independent.
- Illegal destination (x_dest_i >= MESH_SIZE_X or y_dest_i >= MESH_SIZE_Y):
  - The request is still accepted (ready rule unchanged) and err_o=1 in cycle N+1 only.
  - No route is stored: route_valid_o[vc]=0 at N+1, including when a release occurred on that VC in the same cycle.
- req_vc_i >= VC_NUM (non-power-of-2 VC_NUM): req_ready_o=0 and the request is never accepted.
- Inputs are sampled only at a transfer. A request with req_valid_i=0 has no effect.
- Implementation constraint: this block is pure RC. It does no flit buffering and no allocation.

Test Plan:
- Setup for all cases: X_CURRENT=1, Y_CURRENT=1, 4x4 mesh, VC_NUM=2.
- XY basic: YX_ORDER=0, request on vc0 with dest (3,1) -> cycle+1: route_valid_o[0]=1, route_port_o[0]=EAST. Then (1,0) on vc1 -> NORTH. Then, after releasing both, (1,1) on vc0 -> LOCAL, and (0,3) on vc1 -> WEST.
- YX order: YX_ORDER=1, dest (0,3) on vc0 -> SOUTH. Dest (0,1) -> WEST. Dest (1,0) -> NORTH.
- Hold and back-pressure:
  - vc0 holds EAST; a new vc0 request with no release -> req_ready_o=0, and route_port_o[0] stays EAST for 5 cycles.
  - A vc1 request in the same window is accepted.
  - Assert release_i[0] together with a vc0 request for dest (1,3) -> accepted; next cycle route_valid_o[0]=1, route_port_o[0]=SOUTH.
- Release only: release_i=2'b01 with no request -> next cycle route_valid_o=2'b00 (assuming only vc0 was held). Releasing an idle vc1 changes nothing.
- Out-of-mesh: dest (5,1) on vc1 -> accepted; err_o=1 for exactly one cycle; route_valid_o[1]=0. Dest (3,4) gives the same response.
- Reset mid-operation: both VCs hold routes; assert rst for 1 cycle together with a valid request -> next cycle route_valid_o=0, err_o=0, and no route is stored from the request.
